// File: rtl/dcache_sa.sv
// dcache_sa: N-way set-associative, write-back, write-allocate data cache with an
// uncached bypass path and saturating hit/miss counters.
module dcache_sa #(
    parameter int unsigned NUM_SETS       = 8,
    parameter int unsigned NUM_WAYS       = 2,
    parameter int unsigned WORDS_PER_LINE = 16,
    parameter int unsigned UNCACHED_BIT   = 31
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic        dreq_valid,
    input  logic [31:0] dreq_addr,
    input  logic [2:0]  dreq_size,
    input  logic [7:0]  dreq_strobe,
    input  logic [63:0] dreq_data,
    output logic        dresp_addr_ok,
    output logic        dresp_data_ok,
    output logic [63:0] dresp_data,
    output logic        creq_valid,
    output logic        creq_is_write,
    output logic [2:0]  creq_size,
    output logic [31:0] creq_addr,
    output logic [7:0]  creq_strobe,
    output logic [63:0] creq_data,
    output logic [3:0]  creq_len,
    output logic [1:0]  creq_burst,
    input  logic        cresp_ready,
    input  logic        cresp_last,
    input  logic [63:0] cresp_data,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);
    localparam int unsigned WordW = $clog2(WORDS_PER_LINE);
    localparam int unsigned OffW  = 3 + WordW;
    localparam int unsigned IdxW  = $clog2(NUM_SETS);
    localparam int unsigned TagW  = 32 - OffW - IdxW;
    localparam int unsigned WayW  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int unsigned DataW = IdxW + WayW + WordW;
    localparam logic [2:0] MSize8     = 3'b011;
    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [3:0] LineLen    = 4'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {StIdle, StWriteback, StRefill, StUncached} state_e;

    state_e              state_q, state_d;
    logic [WordW-1:0]    beat_q, beat_d;
    logic [WayW-1:0]     way_q, way_d;
    logic                refilled_q;
    logic [31:0]         hit_cnt_q, miss_cnt_q;

    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
    logic [TagW-1:0]     tag_q   [NUM_SETS][NUM_WAYS];
    logic [WayW-1:0]     ptr_q   [NUM_SETS];
    logic [63:0]         data_q  [2**DataW];

    logic [WordW-1:0] word;
    logic [IdxW-1:0]  idx;
    logic [TagW-1:0]  tag;
    logic             uncached;
    logic             hit, has_inv;
    logic [WayW-1:0]  hit_way, inv_way, victim;
    logic             lookup, wb_done, rf_done;

    assign word     = dreq_addr[OffW-1:3];
    assign idx      = dreq_addr[OffW+IdxW-1:OffW];
    assign tag      = dreq_addr[31:OffW+IdxW];
    assign uncached = ~dreq_addr[UNCACHED_BIT];
    assign lookup   = (state_q == StIdle) && dreq_valid && !uncached;
    assign wb_done  = (state_q == StWriteback) && cresp_ready && cresp_last;
    assign rf_done  = (state_q == StRefill) && cresp_ready && cresp_last;
    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        has_inv = 1'b0;
        inv_way = '0;
        for (int w = 0; w < int'(NUM_WAYS); w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WayW'(w);
            end
        end
        // Scan downwards so the lowest-index invalid way wins.
        for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) begin
                has_inv = 1'b1;
                inv_way = WayW'(w);
            end
        end
        victim = has_inv ? inv_way : ptr_q[idx];
    end

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        way_d         = way_q;
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        dresp_data    = '0;
        creq_valid    = 1'b0;
        creq_is_write = 1'b0;
        creq_size     = '0;
        creq_addr     = '0;
        creq_strobe   = '0;
        creq_data     = '0;
        creq_len      = '0;
        creq_burst    = '0;
        unique case (state_q)
            StIdle: begin
                if (dreq_valid) begin
                    if (uncached) begin
                        state_d = StUncached;
                    end else if (hit) begin
                        dresp_addr_ok = 1'b1;
                        dresp_data_ok = 1'b1;
                        dresp_data    = data_q[{idx, hit_way, word}];
                    end else begin
                        way_d   = victim;
                        state_d = (valid_q[idx][victim] && dirty_q[idx][victim]) ?
                                  StWriteback : StRefill;
                    end
                end
            end
            StWriteback: begin
                creq_valid    = 1'b1;
                creq_is_write = 1'b1;
                creq_size     = MSize8;
                creq_addr     = {tag_q[idx][way_q], idx, {OffW{1'b0}}};
                creq_strobe   = 8'hFF;
                creq_data     = data_q[{idx, way_q, beat_q}];
                creq_len      = LineLen;
                creq_burst    = BurstIncr;
                if (cresp_ready) begin
                    beat_d = beat_q + 1'b1;
                    if (cresp_last) begin
                        beat_d  = '0;
                        state_d = StRefill;
                    end
                end
            end
            StRefill: begin
                creq_valid = 1'b1;
                creq_size  = MSize8;
                creq_addr  = {tag, idx, {OffW{1'b0}}};
                creq_len   = LineLen;
                creq_burst = BurstIncr;
                if (cresp_ready) begin
                    beat_d = beat_q + 1'b1;
                    if (cresp_last) begin
                        beat_d  = '0;
                        state_d = StIdle;
                    end
                end
            end
            StUncached: begin
                creq_valid    = 1'b1;
                creq_is_write = |dreq_strobe;
                creq_size     = dreq_size;
                creq_addr     = dreq_addr;
                creq_strobe   = dreq_strobe;
                creq_data     = dreq_data;
                creq_burst    = BurstFixed;
                if (cresp_ready && cresp_last) begin
                    dresp_addr_ok = 1'b1;
                    dresp_data_ok = 1'b1;
                    dresp_data    = cresp_data;
                    state_d       = StIdle;
                end
            end
        endcase
        // Outputs are held quiet for the whole time reset is asserted.
        if (!reset_) begin
            dresp_addr_ok = 1'b0;
            dresp_data_ok = 1'b0;
            dresp_data    = '0;
            creq_valid    = 1'b0;
            creq_is_write = 1'b0;
            creq_size     = '0;
            creq_addr     = '0;
            creq_strobe   = '0;
            creq_data     = '0;
            creq_len      = '0;
            creq_burst    = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q    <= StIdle;
            beat_q     <= '0;
            way_q      <= '0;
            refilled_q <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            for (int s = 0; s < int'(NUM_SETS); s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                ptr_q[s]   <= '0;
                for (int w = 0; w < int'(NUM_WAYS); w++) tag_q[s][w] <= '0;
            end
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            way_q      <= way_d;
            refilled_q <= rf_done;
            if (lookup && hit) begin
                // The replay hit right after a refill was already counted as a miss.
                if (!refilled_q && hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 1'b1;
                if (|dreq_strobe) dirty_q[idx][hit_way] <= 1'b1;
            end
            if (lookup && !hit) begin
                if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 1'b1;
                if (!has_inv) begin
                    ptr_q[idx] <= (ptr_q[idx] == WayW'(NUM_WAYS - 1)) ? '0 : ptr_q[idx] + 1'b1;
                end
            end
            if (wb_done) dirty_q[idx][way_q] <= 1'b0;
            if (rf_done) begin
                valid_q[idx][way_q] <= 1'b1;
                dirty_q[idx][way_q] <= 1'b0;
                tag_q[idx][way_q]   <= tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (lookup && hit) begin
            for (int b = 0; b < 8; b++) begin
                if (dreq_strobe[b]) data_q[{idx, hit_way, word}][8*b +: 8] <= dreq_data[8*b +: 8];
            end
        end
        if (state_q == StRefill && cresp_ready) data_q[{idx, way_q, beat_q}] <= cresp_data;
    end

endmodule

// File: tb/tb_dcache_sa.sv
// Self-checking bench for dcache_sa: burst memory model, architectural golden memory
// and a read-data scoreboard.
module tb_dcache_sa;
    logic        clk = 1'b0;
    logic        reset_ = 1'b0;
    logic        dreq_valid = 1'b0;
    logic [31:0] dreq_addr = '0;
    logic [2:0]  dreq_size = '0;
    logic [7:0]  dreq_strobe = '0;
    logic [63:0] dreq_data = '0;
    logic        dresp_addr_ok, dresp_data_ok;
    logic [63:0] dresp_data;
    logic        creq_valid, creq_is_write;
    logic [2:0]  creq_size;
    logic [31:0] creq_addr;
    logic [7:0]  creq_strobe;
    logic [63:0] creq_data;
    logic [3:0]  creq_len;
    logic [1:0]  creq_burst;
    logic        cresp_ready = 1'b0;
    logic        cresp_last = 1'b0;
    logic [63:0] cresp_data = '0;
    logic [31:0] hit_cnt, miss_cnt;

    dcache_sa #(
        .NUM_SETS(8), .NUM_WAYS(2), .WORDS_PER_LINE(16), .UNCACHED_BIT(31)
    ) dut (
        .clk(clk), .reset_(reset_),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .creq_valid(creq_valid), .creq_is_write(creq_is_write), .creq_size(creq_size),
        .creq_addr(creq_addr), .creq_strobe(creq_strobe), .creq_data(creq_data),
        .creq_len(creq_len), .creq_burst(creq_burst),
        .cresp_ready(cresp_ready), .cresp_last(cresp_last), .cresp_data(cresp_data),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    logic [63:0] mem  [logic [28:0]];
    logic [63:0] gold [logic [28:0]];

    function automatic logic [63:0] pat(input logic [28:0] w);
        return {32'hC0DE_0000 ^ {3'b000, w}, {3'b000, w}};
    endfunction
    function automatic logic [63:0] mem_rd(input logic [28:0] w);
        return mem.exists(w) ? mem[w] : pat(w);
    endfunction
    function automatic logic [63:0] gold_rd(input logic [28:0] w);
        return gold.exists(w) ? gold[w] : pat(w);
    endfunction
    function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] d,
                                          input logic [7:0] s);
        logic [63:0] r;
        r = o;
        for (int b = 0; b < 8; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Memory slave: one beat per cycle while creq_valid, transactions logged on last.
    int unsigned sbeat = 0;
    int unsigned cur_beats = 0;
    logic [28:0] sw;
    logic [31:0] tx_addr [$];
    int unsigned tx_len [$];
    logic        tx_wr [$];
    int unsigned tx_beats [$];

    always @(posedge clk) begin
        if (!reset_) begin
            sbeat = 0;
            cur_beats = 0;
        end else if (creq_valid && cresp_ready) begin
            sw = creq_addr[31:3] + 29'(sbeat);
            if (creq_is_write) mem[sw] = merge(mem_rd(sw), creq_data, creq_strobe);
            cur_beats++;
            if (cresp_last) begin
                tx_addr.push_back(creq_addr);
                tx_len.push_back(int'(creq_len));
                tx_wr.push_back(creq_is_write);
                tx_beats.push_back(cur_beats);
                sbeat = 0;
                cur_beats = 0;
            end else begin
                sbeat++;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        cresp_ready = creq_valid;
        cresp_last  = creq_valid && (sbeat == int'(creq_len));
        cresp_data  = creq_valid ? mem_rd(creq_addr[31:3] + 29'(sbeat)) : 64'h0;
    end

    // Scoreboard: expected read data pushed at issue, popped on data_ok.
    logic [63:0] sb [$];
    always @(negedge clk) begin
        if (reset_ && (dresp_addr_ok || dresp_data_ok)) begin
            check("ok_pair", 64'(dresp_addr_ok), 64'(dresp_data_ok));
            if (dresp_data_ok && dreq_strobe == 8'h00) begin
                if (sb.size() == 0) check("sb_underflow", 64'(sb.size()), 64'd1);
                else check("rdata", dresp_data, sb.pop_front());
            end
        end
    end

    task automatic clear_tx();
        tx_addr.delete();
        tx_len.delete();
        tx_wr.delete();
        tx_beats.delete();
    endtask

    task automatic check_tx(input string name, input int i, input logic [31:0] a,
                            input int unsigned len, input logic wr, input int unsigned beats);
        if (tx_addr.size() > i) begin
            check({name, "_addr"}, 64'(tx_addr[i]), 64'(a));
            check({name, "_len"}, 64'(tx_len[i]), 64'(len));
            check({name, "_wr"}, 64'(tx_wr[i]), 64'(wr));
            check({name, "_beats"}, 64'(tx_beats[i]), 64'(beats));
        end else begin
            check({name, "_present"}, 64'(tx_addr.size()), 64'(i + 1));
        end
    endtask

    // Called just after a rising edge; returns the cycles spent waiting for addr_ok.
    task automatic access(input logic [31:0] a, input logic [7:0] s, input logic [63:0] d,
                          output int lat);
        logic [28:0] w;
        w = a[31:3];
        if (s == 8'h00) sb.push_back(gold_rd(w));
        else gold[w] = merge(gold_rd(w), d, s);
        clear_tx();
        dreq_valid  = 1'b1;
        dreq_addr   = a;
        dreq_size   = 3'd3;
        dreq_strobe = s;
        dreq_data   = d;
        lat = 0;
        forever begin
            @(negedge clk);
            if (dresp_addr_ok) break;
            lat++;
            if (lat > 200) begin
                check("timeout", 64'(lat), 64'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        dreq_valid = 1'b0;
    endtask

    initial begin
        int lat;
        int k;
        repeat (3) @(posedge clk);
        #1;
        check("rst_creq_valid", 64'(creq_valid), 64'd0);
        check("rst_addr_ok", 64'(dresp_addr_ok), 64'd0);
        check("rst_hit", 64'(hit_cnt), 64'd0);
        check("rst_miss", 64'(miss_cnt), 64'd0);
        reset_ = 1'b1;
        @(posedge clk);
        #1;

        access(32'h8000_0040, 8'h00, 64'h0, lat);
        check("cold_lat", 64'(lat), 64'd17);
        check("cold_ntx", 64'(tx_addr.size()), 64'd1);
        check_tx("cold_refill", 0, 32'h8000_0000, 15, 1'b0, 16);
        check("cold_miss", 64'(miss_cnt), 64'd1);
        check("cold_hit", 64'(hit_cnt), 64'd0);

        access(32'h8000_0048, 8'h00, 64'h0, lat);
        check("hit_lat", 64'(lat), 64'd0);
        check("hit_ntx", 64'(tx_addr.size()), 64'd0);
        check("hit_cnt1", 64'(hit_cnt), 64'd1);

        clear_tx();
        repeat (5) @(posedge clk);
        #1;
        check("idle_ntx", 64'(tx_addr.size()), 64'd0);
        check("idle_creq_valid", 64'(creq_valid), 64'd0);

        access(32'h8000_0040, 8'h0F, 64'h1122_3344_5566_7788, lat);
        check("wr_lat", 64'(lat), 64'd0);
        access(32'h8000_0040, 8'h00, 64'h0, lat);
        check("rdback_lat", 64'(lat), 64'd0);
        check("rdback_ntx", 64'(tx_addr.size()), 64'd0);
        check("wr_hit_cnt", 64'(hit_cnt), 64'd3);

        // Second tag into set 0 fills the remaining invalid way.
        access(32'h8000_0400, 8'h00, 64'h0, lat);
        check("fill_w1_ntx", 64'(tx_addr.size()), 64'd1);
        check_tx("fill_w1", 0, 32'h8000_0400, 15, 1'b0, 16);
        check("fill_w1_miss", 64'(miss_cnt), 64'd2);

        // Third tag evicts the dirty line A.
        access(32'h8000_0800, 8'h00, 64'h0, lat);
        check("evict_lat", 64'(lat), 64'd33);
        check("evict_ntx", 64'(tx_addr.size()), 64'd2);
        check_tx("evict_wb", 0, 32'h8000_0000, 15, 1'b1, 16);
        check_tx("evict_rf", 1, 32'h8000_0800, 15, 1'b0, 16);
        check("evict_miss", 64'(miss_cnt), 64'd3);
        check("evict_hit", 64'(hit_cnt), 64'd3);
        check("wb_data_w8", mem_rd(29'h1000_0008), gold_rd(29'h1000_0008));
        check("wb_data_w0", mem_rd(29'h1000_0000), gold_rd(29'h1000_0000));

        // All ways valid, victim pointer now at the clean way: refill only.
        access(32'h8000_0040, 8'h00, 64'h0, lat);
        check("clean_ntx", 64'(tx_addr.size()), 64'd1);
        check_tx("clean_rf", 0, 32'h8000_0000, 15, 1'b0, 16);
        check("clean_miss", 64'(miss_cnt), 64'd4);

        access(32'h1000_0000, 8'hFF, 64'hDEAD_BEEF_0BAD_F00D, lat);
        check("unc_wr_lat", 64'(lat), 64'd1);
        check("unc_wr_ntx", 64'(tx_addr.size()), 64'd1);
        check_tx("unc_wr", 0, 32'h1000_0000, 0, 1'b1, 1);
        access(32'h1000_0000, 8'h00, 64'h0, lat);
        check("unc_rd_ntx", 64'(tx_addr.size()), 64'd1);
        check_tx("unc_rd", 0, 32'h1000_0000, 0, 1'b0, 1);
        check("unc_hit", 64'(hit_cnt), 64'd3);
        check("unc_miss", 64'(miss_cnt), 64'd4);

        // Reset in the middle of a refill.
        clear_tx();
        dreq_valid  = 1'b1;
        dreq_addr   = 32'h8000_0080;
        dreq_strobe = 8'h00;
        k = 0;
        while (!(creq_valid && sbeat == 5) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("abort_reach_beat5", 64'(sbeat), 64'd5);
        #2;
        reset_ = 1'b0;
        #1;
        check("abort_creq_valid", 64'(creq_valid), 64'd0);
        check("abort_data_ok", 64'(dresp_data_ok), 64'd0);
        check("abort_miss", 64'(miss_cnt), 64'd0);
        dreq_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_ = 1'b1;
        @(posedge clk);
        #1;
        access(32'h8000_0080, 8'h00, 64'h0, lat);
        check("rerun_lat", 64'(lat), 64'd17);
        check("rerun_ntx", 64'(tx_addr.size()), 64'd1);
        check_tx("rerun_rf", 0, 32'h8000_0080, 15, 1'b0, 16);
        check("rerun_miss", 64'(miss_cnt), 64'd1);
        check("rerun_hit", 64'(hit_cnt), 64'd0);

        repeat (2) @(posedge clk);
        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dcache_sa.md
Name: dcache_sa

Overview:
- Parametrised N-way set-associative, write-back, write-allocate data cache between the core's dbus and the cbus memory port.
- Successor to the fixed direct-mapped DCache; instantiated in VCacheTop in place of DCache.
- Adds configurable sets, ways and line length, an uncached bypass path, and hit/miss performance counters.

Parameters:
- NUM_SETS, 8, number of sets; power of two, minimum 2.
- NUM_WAYS, 2, associativity; power of two, 1..8.
- WORDS_PER_LINE, 16, 64-bit words per line; one of 2/4/8/16; equals the cbus burst length.
- UNCACHED_BIT, 31, address bit selecting the region; addr[UNCACHED_BIT]==0 is uncached.

Ports:
- clk  in  1  clock.
- reset_  in  1  asynchronous active-low reset.
- dreq  in  dbus_req_t  core request: valid, addr, size, strobe, data.
- dresp  out  dbus_resp_t  addr_ok, data_ok, data.
- creq  out  cbus_req_t  memory request: valid, is_write, size, addr, strobe, data, len, burst.
- cresp  in  cbus_resp_t  ready, last, data.
- hit_cnt  out  32  cached accesses that hit on first lookup; saturating.
- miss_cnt  out  32  cached accesses that missed; saturating.

Behaviour:
- Address split: offset = 3 + log2(WORDS_PER_LINE) bits; index = log2(NUM_SETS) bits; tag = the remaining upper bits.
- Per-line storage: valid, dirty, tag, data. Each set also holds one round-robin victim pointer of log2(NUM_WAYS) bits.
- Reset (reset_ low, asynchronous):
  - All valid/dirty bits cleared, victim pointers 0, counters 0, state IDLE.
  - dresp and creq all-zero while reset_ is low.
  - Data array contents are don't-care.
- Requester protocol: the core holds dreq stable until addr_ok. addr_ok and data_ok are pulsed together for exactly one cycle.
- States: IDLE, WRITEBACK, REFILL, UNCACHED.
- IDLE, dreq.valid, cached hit:
  - addr_ok = data_ok = 1 in the same cycle (combinational hit, zero-wait).
  - Read: dresp.data = the full 64-bit word.
  - Write: bytes selected by strobe are merged at the clock edge and dirty is set.
  - hit_cnt increments once.
- IDLE, dreq.valid, cached miss:
  - miss_cnt increments once.
  - Victim choice: the lowest-index invalid way; otherwise the way at the victim pointer, after which the pointer advances modulo NUM_WAYS.
  - Victim valid and dirty: go to WRITEBACK. Otherwise go to REFILL.
- WRITEBACK:
  - creq.valid=1, is_write=1, addr={victim tag, index, 0}, size=MSIZE8, strobe=8'hFF, len=WORDS_PER_LINE-1, burst=INCR.
  - creq.data = the current beat's word; the beat counter advances on cresp.ready.
  - On ready && last: clear dirty, go to REFILL.
- REFILL:
  - creq.valid=1, is_write=0, addr={req tag, index, 0}, same size/len/burst.
  - Each ready beat writes cresp.data to word[beat].
  - On last: set valid=1, dirty=0, tag=req tag, return to IDLE.
  - The held request then hits on the next cycle; it is not counted again in hit_cnt.
- Uncached request (addr[UNCACHED_BIT]==0):
  - From IDLE go to UNCACHED.
  - Single beat: len=MLEN1, size from dreq.size, addr=dreq.addr, strobe/data passed through.
  - On ready && last: addr_ok = data_ok = 1 in that cycle, dresp.data=cresp.data, return to IDLE.
  - Cache state and counters are unchanged.
- creq.valid stays high from state entry until the last handshake, and is low in IDLE.
- Beat counters wrap to 0 on state exit.
- Counters saturate at 32'hFFFF_FFFF.
- Boundary conditions:
  - dreq.valid low in IDLE: no state change.
  - Reset asserted mid-burst: the burst is abandoned immediately. No partial line is marked valid.
  - A miss on a set whose ways are all valid and clean: no WRITEBACK state.

Test Plan:
- Cold read 0x8000_0040 → one REFILL burst (addr 0x8000_0000, len 15, 16 beats); data_ok the cycle after last with word 8; miss_cnt=1, hit_cnt=0.
- Read 0x8000_0048 immediately after → addr_ok = data_ok in the same cycle as valid, no creq.valid; hit_cnt=1.
- Write 0x8000_0040 data 0x1122334455667788 strobe 0x0F, then read it back → low 4 bytes updated, upper 4 bytes unchanged; no cbus traffic.
- Dirty line at tag A in set 0 of a 2-way cache, fill way 1, then read a third tag in set 0 → WRITEBACK of 16 beats to A's line address carrying the written data, then REFILL; miss_cnt increments by 1.
- Write to 0x1000_0000 (uncached), strobe 0xFF → single cbus write (len MLEN1, addr 0x1000_0000); no cache line becomes valid; counters unchanged.
- Assert reset_ low at beat 5 of a REFILL → creq.valid drops asynchronously. A repeat of the same read after reset misses again and performs a full refill.
